// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_queue
// Purpose : Writeback FIFO draining onto the register file write port, with
//           read-after-write hazard flags for the addresses on the read port.
// Revision: 1.0  initial release
// ============================================================================
module regfile_wb_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int RD_DEPTH    = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           rf_en_n,
  output logic                           wr,
  output logic [ADDR_WIDTH-1:0]          rw,
  output logic [DATA_WIDTH-1:0]          d,
  input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
  output logic [RD_DEPTH-1:0]            hazard,
  output logic [$clog2(QUEUE_DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(QUEUE_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [ADDR_WIDTH-1:0]  r_addr [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  r_data [QUEUE_DEPTH];
  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [c_cnt_w-1:0]     r_count;
  logic                   r_wr;
  logic [ADDR_WIDTH-1:0]  r_rw;
  logic [DATA_WIDTH-1:0]  r_d;

  logic                   w_push;
  logic                   w_pop;
  logic [QUEUE_DEPTH-1:0] w_entry_valid;

  assign in_ready = (r_count < c_cnt_w'(QUEUE_DEPTH));
  // Address-0 requests complete the handshake but are dropped here.
  assign w_push   = in_valid && in_ready && (in_addr != '0);
  assign w_pop    = (r_count != '0) && !rf_en_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr     <= 1'b0;
      r_rw     <= '0;
      r_d      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      r_wr <= w_pop;
      if (w_pop) begin
        r_rw <= r_addr[r_rd_ptr];
        r_d  <= r_data[r_rd_ptr];
      end
    end
  end

  // Storage needs no reset: occupancy is tracked solely by pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= in_addr;
      r_data[r_wr_ptr] <= in_data;
    end
  end

  generate
    for (genvar j = 0; j < QUEUE_DEPTH; j++) begin : g_valid
      logic [c_ptr_w-1:0] w_off;
      assign w_off            = c_ptr_w'(j) - r_rd_ptr;
      assign w_entry_valid[j] = ({1'b0, w_off} < r_count);
    end
  endgenerate

  generate
    for (genvar i = 0; i < RD_DEPTH; i++) begin : g_hazard
      logic [ADDR_WIDTH-1:0] w_rd;
      logic                  w_hit;
      assign w_rd = rr[ADDR_WIDTH*i +: ADDR_WIDTH];
      always_comb begin
        w_hit = r_wr && (r_rw == w_rd);
        for (int j = 0; j < QUEUE_DEPTH; j++) begin
          if (w_entry_valid[j] && (r_addr[j] == w_rd)) w_hit = 1'b1;
        end
      end
      assign hazard[i] = w_hit && (w_rd != '0);
    end
  endgenerate

  assign wr    = r_wr;
  assign rw    = r_rw;
  assign d     = r_d;
  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_queue
// Purpose : Directed self-checking bench for regfile_wb_queue.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        rf_en_n;
  logic        wr;
  logic [4:0]  rw;
  logic [31:0] d;
  logic [9:0]  rr;
  logic [1:0]  hazard;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  regfile_wb_queue #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_DEPTH(2), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .rf_en_n(rf_en_n),
    .wr(wr), .rw(rw), .d(d), .rr(rr), .hazard(hazard), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h1234_5678;
    rf_en_n = 1'b0; rr = {5'd5, 5'd5};
    #22;
    // Reset held across edges with a request pending
    chk("rst_wr", wr, 0);
    chk("rst_rw", rw, 0);
    chk("rst_d", d, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hazard", hazard, 2'b00);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_count", count, 0);
    chk("post_rst_wr", wr, 0);

    // Single write
    in_valid = 1'b1; in_addr = 5'd27; in_data = 32'hdcaf484c; rr = '0;
    tick();
    in_valid = 1'b0;
    chk("single_count_n", count, 1);
    chk("single_wr_n", wr, 0);
    tick();
    chk("single_count_n1", count, 0);
    chk("single_wr_n1", wr, 1);
    chk("single_rw", rw, 27);
    chk("single_d", d, 32'hdcaf484c);
    tick();
    chk("single_wr_off", wr, 0);
    chk("single_rw_hold", rw, 27);

    // Fill with draining stalled
    rf_en_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_addr = 5'(k); in_data = 32'(100 + k);
      tick();
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    in_addr = 5'd5; in_data = 32'd105;
    tick();
    chk("full_held_count", count, 4);
    chk("full_held_wr", wr, 0);
    rf_en_n = 1'b0;
    tick();
    chk("drain1_rw", rw, 1);
    chk("drain1_wr", wr, 1);
    chk("drain1_count", count, 3);
    chk("drain1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("drain2_rw", rw, 2);
    chk("drain2_count", count, 3);
    tick();
    chk("drain3_rw", rw, 3);
    chk("drain3_wr", wr, 1);
    tick();
    chk("drain4_rw", rw, 4);
    chk("drain4_d", d, 104);
    tick();
    chk("drain5_rw", rw, 5);
    chk("drain5_d", d, 105);
    chk("drain5_wr", wr, 1);
    chk("drain5_count", count, 0);
    tick();
    chk("drain_done_wr", wr, 0);

    // Address 0 is consumed but never queued
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h37373737; rr = {5'd27, 5'd0};
    #1;
    chk("a0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("a0_count", count, 0);
    chk("a0_wr", wr, 0);
    chk("a0_hazard", hazard, 2'b00);
    tick();
    chk("a0_wr_later", wr, 0);

    // Hazard tracking through queue and output stage
    rf_en_n = 1'b1;
    in_valid = 1'b1; in_addr = 5'd4; in_data = 32'h44;
    tick();
    in_valid = 1'b0;
    rr = {5'd27, 5'd4};
    #1;
    chk("haz_queued", hazard, 2'b01);
    rr = {5'd4, 5'd4};
    #1;
    chk("haz_both", hazard, 2'b11);
    rr = {5'd27, 5'd4};
    tick();
    chk("haz_stalled", hazard, 2'b01);
    rf_en_n = 1'b0;
    tick();
    chk("haz_out_wr", wr, 1);
    chk("haz_out_rw", rw, 4);
    chk("haz_out_stage", hazard, 2'b01);
    tick();
    chk("haz_cleared", hazard, 2'b00);

    // Reset mid-operation discards queue and in-flight write
    rf_en_n = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      in_valid = 1'b1; in_addr = 5'(k); in_data = 32'(k);
      tick();
    end
    in_valid = 1'b0;
    rf_en_n = 1'b0;
    tick();
    chk("mid_pre_wr", wr, 1);
    chk("mid_pre_count", count, 3);
    rf_en_n = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wr", wr, 0);
    chk("mid_rst_rw", rw, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    #2 rst = 1'b0;
    rf_en_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("after_rst_wr", wr, 0);
      chk("after_rst_count", count, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
